// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline stage: occupancy encodings and default widths.
package pipe_pkg;
  localparam int DATA_W_DEF = 16;
  localparam int CTRL_W_DEF = 5;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;
endpackage

// File: rtl/pipe_entry.sv
// One pipeline entry: valid + ctrl + data. Clear drops the beat to a NOP but keeps the payload.
module pipe_entry #(
  parameter int DATA_W = 16,
  parameter int CTRL_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              clear_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o
);
  logic              valid_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic [DATA_W-1:0] data_q;

  // Clear wins over load so a flush discards any beat arriving in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
    end else if (clear_i) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      ctrl_q  <= ctrl_i;
      data_q  <= data_i;
    end
  end

  assign valid_o = valid_q;
  assign ctrl_o  = ctrl_q;
  assign data_o  = data_q;
endmodule

// File: rtl/elastic_pipe_stage.sv
// Valid/ready pipeline register with optional skid entry; flush turns the stage into a bubble.
module elastic_pipe_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CTRL_W = CTRL_W_DEF,
  parameter bit SKID   = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);
  occ_e              occ_q, occ_d;
  logic              in_fire, out_fire;
  logic              main_load, main_clear, skid_load, skid_clear;
  logic              main_valid, skid_valid;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_ctrl_in;
  logic [DATA_W-1:0] main_data, skid_data, main_data_in;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = main_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) occ_q <= OCC_EMPTY;
    else        occ_q <= occ_d;
  end

  always_comb begin
    occ_d      = occ_q;
    main_load  = 1'b0;
    main_clear = 1'b0;
    skid_load  = 1'b0;
    skid_clear = 1'b0;
    if (flush) begin
      occ_d      = OCC_EMPTY;
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else begin
      case (occ_q)
        OCC_EMPTY: if (in_fire) begin
          main_load = 1'b1;
          occ_d     = OCC_ONE;
        end
        OCC_ONE: begin
          if (in_fire && out_fire) begin
            main_load = 1'b1;
          end else if (in_fire && SKID) begin
            skid_load = 1'b1;
            occ_d     = OCC_FULL;
          end else if (out_fire) begin
            main_clear = 1'b1;
            occ_d      = OCC_EMPTY;
          end
        end
        OCC_FULL: if (out_fire) begin
          main_load  = 1'b1;
          skid_clear = 1'b1;
          occ_d      = OCC_ONE;
        end
        default: occ_d = OCC_EMPTY;
      endcase
    end
  end

  // Main refills from the skid when draining a full stage, otherwise from upstream.
  assign main_ctrl_in = skid_valid ? skid_ctrl : in_ctrl;
  assign main_data_in = skid_valid ? skid_data : in_data;

  pipe_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
    .clk(clk), .rst_n(rst_n), .load_i(main_load), .clear_i(main_clear),
    .ctrl_i(main_ctrl_in), .data_i(main_data_in),
    .valid_o(main_valid), .ctrl_o(main_ctrl), .data_o(main_data)
  );

  generate
    if (SKID) begin : g_skid
      logic rdy_q;

      pipe_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
        .clk(clk), .rst_n(rst_n), .load_i(skid_load), .clear_i(skid_clear),
        .ctrl_i(in_ctrl), .data_i(in_data),
        .valid_o(skid_valid), .ctrl_o(skid_ctrl), .data_o(skid_data)
      );

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdy_q <= 1'b1;
        else        rdy_q <= (occ_d != OCC_FULL);
      end
      assign in_ready = rdy_q;
    end else begin : g_noskid
      assign skid_valid = 1'b0;
      assign skid_ctrl  = '0;
      assign skid_data  = '0;
      assign in_ready   = ~main_valid | out_ready;
    end
  endgenerate

  assign out_valid = main_valid;
  assign out_ctrl  = main_valid ? main_ctrl : '0;
  assign out_data  = main_data;
  assign occupancy = occ_q;
endmodule

// File: tb/tb_elastic_pipe_stage.sv
// Directed bench for elastic_pipe_stage: SKID=1 instance for most scenarios, SKID=0 for pass-through.
module tb_elastic_pipe_stage;
  localparam int DW = 16;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          rst_n, flush, in_valid, out_ready;
  logic [CW-1:0] in_ctrl;
  logic [DW-1:0] in_data;

  logic          in_ready, out_valid;
  logic [CW-1:0] out_ctrl;
  logic [DW-1:0] out_data;
  logic [1:0]    occ;

  logic          in_ready0, out_valid0;
  logic [CW-1:0] out_ctrl0;
  logic [DW-1:0] out_data0;
  logic [1:0]    occ0;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  elastic_pipe_stage #(.DATA_W(DW), .CTRL_W(CW), .SKID(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_data(out_data), .occupancy(occ)
  );

  elastic_pipe_stage #(.DATA_W(DW), .CTRL_W(CW), .SKID(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready0),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid0), .out_ready(out_ready),
    .out_ctrl(out_ctrl0), .out_data(out_data0), .occupancy(occ0)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    in_ctrl = 5'h1f; in_data = 16'hdead;
    tick(); tick();
    vecs++; if (out_valid !== 1'b0) begin errs++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
    vecs++; if (out_ctrl !== '0) begin errs++; $display("FAIL rst_out_ctrl got %h exp 0", out_ctrl); end
    vecs++; if (out_data !== '0) begin errs++; $display("FAIL rst_out_data got %h exp 0", out_data); end
    vecs++; if (occ !== 2'd0) begin errs++; $display("FAIL rst_occ got %0d exp 0", occ); end
    in_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL rst_in_ready got %b exp 1", in_ready); end
    vecs++; if (in_ready0 !== 1'b1) begin errs++; $display("FAIL rst_in_ready0 got %b exp 1", in_ready0); end
  endtask

  task automatic test_stream();
    out_ready = 1'b1; in_valid = 1'b1; in_ctrl = 5'h03;
    for (int i = 1; i <= 4; i++) begin
      in_data = DW'(i);
      tick();
      vecs++; if (out_valid !== 1'b1 || out_data !== DW'(i))
        begin errs++; $display("FAIL stream_%0d got v=%b d=%h exp v=1 d=%h", i, out_valid, out_data, i); end
      vecs++; if (out_ctrl !== 5'h03 || in_ready !== 1'b1)
        begin errs++; $display("FAIL stream_ctl_%0d got c=%h rdy=%b exp c=03 rdy=1", i, out_ctrl, in_ready); end
    end
    in_valid = 1'b0;
    tick();
    vecs++; if (out_valid !== 1'b0 || occ !== 2'd0)
      begin errs++; $display("FAIL stream_drain got v=%b occ=%0d exp v=0 occ=0", out_valid, occ); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 5'h01; in_data = 16'haaaa;
    tick();
    vecs++; if (occ !== 2'd1 || in_ready !== 1'b1)
      begin errs++; $display("FAIL bp_one got occ=%0d rdy=%b exp occ=1 rdy=1", occ, in_ready); end
    in_data = 16'hbbbb;
    tick();
    vecs++; if (occ !== 2'd2 || in_ready !== 1'b0)
      begin errs++; $display("FAIL bp_full got occ=%0d rdy=%b exp occ=2 rdy=0", occ, in_ready); end
    in_data = 16'hcccc;
    tick();
    vecs++; if (occ !== 2'd2 || out_data !== 16'haaaa || out_valid !== 1'b1)
      begin errs++; $display("FAIL bp_hold got occ=%0d d=%h v=%b exp occ=2 d=aaaa v=1", occ, out_data, out_valid); end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    vecs++; if (out_data !== 16'hbbbb || occ !== 2'd1 || in_ready !== 1'b1)
      begin errs++; $display("FAIL bp_second got d=%h occ=%0d rdy=%b exp d=bbbb occ=1 rdy=1", out_data, occ, in_ready); end
    tick();
    vecs++; if (out_valid !== 1'b0 || occ !== 2'd0)
      begin errs++; $display("FAIL bp_empty got v=%b occ=%0d exp v=0 occ=0", out_valid, occ); end
    out_ready = 1'b0;
  endtask

  task automatic test_flush_full();
    out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 5'h1f; in_data = 16'h1111;
    tick();
    in_data = 16'h2222;
    tick();
    vecs++; if (occ !== 2'd2 || out_ctrl !== 5'h1f)
      begin errs++; $display("FAIL ff_pre got occ=%0d c=%h exp occ=2 c=1f", occ, out_ctrl); end
    in_valid = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    vecs++; if (occ !== 2'd0 || out_valid !== 1'b0 || out_ctrl !== '0 || in_ready !== 1'b1)
      begin errs++; $display("FAIL ff_post got occ=%0d v=%b c=%h rdy=%b exp 0 0 00 1", occ, out_valid, out_ctrl, in_ready); end
    vecs++; if (out_data !== 16'h1111)
      begin errs++; $display("FAIL ff_data_kept got %h exp 1111", out_data); end
    out_ready = 1'b1;
    tick();
    vecs++; if (out_valid !== 1'b0 || occ !== 2'd0)
      begin errs++; $display("FAIL ff_noreappear got v=%b occ=%0d exp v=0 occ=0", out_valid, occ); end
    out_ready = 1'b0;
  endtask

  task automatic test_flush_fire();
    out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 5'h07; in_data = 16'h5555;
    tick();
    in_data = 16'h6666; in_ctrl = 5'h0f; out_ready = 1'b1; flush = 1'b1;
    #1;
    vecs++; if (out_valid !== 1'b1 || out_data !== 16'h5555 || out_ctrl !== 5'h07 || in_ready !== 1'b1)
      begin errs++; $display("FAIL fx_old got v=%b d=%h c=%h rdy=%b exp 1 5555 07 1", out_valid, out_data, out_ctrl, in_ready); end
    tick();
    flush = 1'b0; in_valid = 1'b0;
    vecs++; if (occ !== 2'd0 || out_valid !== 1'b0 || out_ctrl !== '0)
      begin errs++; $display("FAIL fx_empty got occ=%0d v=%b c=%h exp 0 0 00", occ, out_valid, out_ctrl); end
    tick();
    vecs++; if (out_valid !== 1'b0 || occ !== 2'd0)
      begin errs++; $display("FAIL fx_dropped got v=%b occ=%0d exp 0 0", out_valid, occ); end
    out_ready = 1'b0;
  endtask

  task automatic test_skid0();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
    in_valid = 1'b1; in_ctrl = 5'h02; in_data = 16'h0101;
    tick();
    in_data = 16'h0202;
    #1;
    vecs++; if (in_ready0 !== 1'b0 || occ0 !== 2'd1 || out_data0 !== 16'h0101)
      begin errs++; $display("FAIL s0_stall got rdy=%b occ=%0d d=%h exp 0 1 0101", in_ready0, occ0, out_data0); end
    out_ready = 1'b1;
    #1;
    vecs++; if (in_ready0 !== 1'b1)
      begin errs++; $display("FAIL s0_ready_comb got %b exp 1", in_ready0); end
    for (int i = 2; i <= 4; i++) begin
      tick();
      vecs++; if (out_valid0 !== 1'b1 || out_data0 !== {2{8'(i)}} || out_ctrl0 !== 5'h02)
        begin errs++; $display("FAIL s0_pass_%0d got v=%b d=%h c=%h exp v=1 d=%h c=02", i, out_valid0, out_data0, out_ctrl0, {2{8'(i)}}); end
      in_data = {2{8'(i + 1)}};
      if (i == 4) in_valid = 1'b0;
    end
    tick();
    vecs++; if (out_valid0 !== 1'b0 || out_ctrl0 !== '0 || occ0 !== 2'd0)
      begin errs++; $display("FAIL s0_drain got v=%b c=%h occ=%0d exp 0 00 0", out_valid0, out_ctrl0, occ0); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush_full();
    test_flush_fire();
    test_skid0();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
